// File: rtl/rtc_bus_pkg.sv
// Shared types and timing defaults for the RTC multiplexed-bus master.
package rtc_bus_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STB,
    ADDR_HOLD,
    TURN,
    DATA_STB,
    DATA_HOLD,
    RECOVER,
    DONE
  } state_e;

  localparam int T_SETUP_DEF = 1;
  localparam int T_STB_DEF   = 3;
  localparam int T_HOLD_DEF  = 1;
  localparam int T_TURN_DEF  = 1;
  localparam int T_REC_DEF   = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width that holds the longest phase; zero-length phases still count one cycle.
  function automatic int cnt_w(input int max_t);
    return $clog2(max2(max_t, 1) + 1);
  endfunction

endpackage

// File: rtl/rtc_bus_master_timer.sv
// Phase down-counter: loaded with a phase length on state entry, flags the
// final cycle of that phase.
module rtc_phase_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] len,
  output logic          last
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= CW'(1);
    end else if (load) begin
      cnt <= len;
    end else if (cnt > CW'(1)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/rtc_bus_master.sv
// RTC multiplexed address/data bus master: single or burst register transfers
// with parameterised phase timing; every pin and status output is registered.
module rtc_bus_master
  import rtc_bus_pkg::*;
#(
  parameter int DW       = 8,
  parameter int LW       = 4,
  parameter int T_SETUP  = T_SETUP_DEF,
  parameter int T_STB    = T_STB_DEF,
  parameter int T_HOLD   = T_HOLD_DEF,
  parameter int T_TURN   = T_TURN_DEF,
  parameter int T_REC    = T_REC_DEF,
  parameter int ADDR_INC = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          rw,
  input  logic [DW-1:0] addr,
  input  logic [LW-1:0] burst_len,
  input  logic [DW-1:0] wdata,
  output logic          wdata_take,
  output logic [DW-1:0] rdata,
  output logic          rdata_valid,
  output logic          busy,
  output logic          done,
  inout  wire  [DW-1:0] add_data_rtc,
  output logic          a_d_s,
  output logic          cs_s,
  output logic          rd_s,
  output logic          wr_s
);

  localparam int CW = cnt_w(max2(max2(max2(T_SETUP, T_STB), max2(T_HOLD, T_TURN)), T_REC));

  state_e        state, state_n;
  logic          last, load;
  logic [CW-1:0] len_n;
  logic          rw_q;
  logic [LW-1:0] len_q, word_cnt;
  logic [DW-1:0] addr_q, addr_n, bus_out, bus_out_n;
  logic          bus_oe, final_word;
  logic          addr_phase_n, wr_data_n, take_n, rvalid_n;

  function automatic logic [CW-1:0] phase_len(input state_e s);
    int n;
    case (s)
      ADDR_SETUP:          n = T_SETUP;
      ADDR_STB, DATA_STB:  n = T_STB;
      ADDR_HOLD, DATA_HOLD: n = T_HOLD;
      TURN:                n = T_TURN;
      RECOVER:             n = T_REC;
      default:             n = 1;
    endcase
    return CW'(max2(n, 1));
  endfunction

  assign load       = (state_n != state);
  assign len_n      = phase_len(state_n);
  assign final_word = ((word_cnt + LW'(1)) == ((len_q == '0) ? LW'(1) : len_q));

  rtc_phase_timer #(.CW(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .len   (len_n),
    .last  (last)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:       if (req)  state_n = ADDR_SETUP;
      ADDR_SETUP: if (last) state_n = ADDR_STB;
      ADDR_STB:   if (last) state_n = ADDR_HOLD;
      ADDR_HOLD:  if (last) state_n = TURN;
      TURN:       if (last) state_n = DATA_STB;
      DATA_STB:   if (last) state_n = DATA_HOLD;
      DATA_HOLD:  if (last) state_n = RECOVER;
      RECOVER:    if (last) state_n = final_word ? DONE : ADDR_SETUP;
      DONE:       state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with the state register.
  always_comb begin
    addr_n = addr_q;
    if (state == IDLE) begin
      addr_n = addr;
    end else if (state == RECOVER && state_n == ADDR_SETUP) begin
      addr_n = addr_q + DW'(ADDR_INC);
    end
    addr_phase_n = (state_n inside {ADDR_SETUP, ADDR_STB, ADDR_HOLD});
    wr_data_n    = rw_q && ((state_n inside {DATA_STB, DATA_HOLD}) ||
                            (state_n == TURN && state == TURN));
    take_n       = rw_q && (state_n == TURN) && (state != TURN);
    rvalid_n     = !rw_q && (state == DATA_STB) && (state_n == DATA_HOLD);
    bus_out_n    = bus_out;
    if (addr_phase_n) begin
      bus_out_n = addr_n;
    end else if (wdata_take) begin
      bus_out_n = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      wdata_take  <= 1'b0;
      rdata_valid <= 1'b0;
      rdata       <= '0;
      a_d_s       <= 1'b1;
      cs_s        <= 1'b1;
      rd_s        <= 1'b1;
      wr_s        <= 1'b1;
      bus_oe      <= 1'b0;
      rw_q        <= 1'b0;
      len_q       <= '0;
      word_cnt    <= '0;
    end else begin
      state       <= state_n;
      busy        <= (state_n != IDLE);
      done        <= (state_n == DONE);
      wdata_take  <= take_n;
      rdata_valid <= rvalid_n;
      if (rvalid_n) rdata <= add_data_rtc;
      a_d_s       <= !addr_phase_n;
      cs_s        <= !(state_n == ADDR_STB || state_n == DATA_STB);
      wr_s        <= !(state_n == ADDR_STB || (state_n == DATA_STB && rw_q));
      rd_s        <= !(state_n == DATA_STB && !rw_q);
      bus_oe      <= addr_phase_n || wr_data_n;
      if (state == IDLE && req) begin
        rw_q     <= rw;
        len_q    <= burst_len;
        word_cnt <= '0;
      end else if (state == RECOVER && last) begin
        word_cnt <= word_cnt + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    bus_out <= bus_out_n;
    if ((state == IDLE && req) || (state == RECOVER && state_n == ADDR_SETUP)) begin
      addr_q <= addr_n;
    end
  end

  assign add_data_rtc = bus_oe ? bus_out : {DW{1'bz}};

endmodule

// File: tb/tb_rtc_bus_master.sv
// Directed bench for rtc_bus_master: three instances cover default timing,
// fixed-address bursts and a zero-length strobe parameter.
module tb_rtc_bus_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_v [3];
  logic       rw;
  logic [7:0] addr;
  logic [3:0] burst_len;
  logic [7:0] wdata;
  logic       take_v [3], rv_v [3], busy_v [3], done_v [3];
  logic       ad_v [3], cs_v [3], rd_v [3], wr_v [3];
  logic [7:0] rdata_v [3];
  wire  [7:0] bus0, bus1, bus2;

  // RTC model on instance 0: latches the register address, answers whenever A/D is high.
  logic       model_en, model_inc;
  logic [7:0] lat;
  logic [7:0] model_val;
  assign model_val = model_inc ? lat + 8'd1 : 8'h37;
  assign bus0 = (model_en && ad_v[0]) ? model_val : 8'hzz;
  always @(posedge clk) if (!ad_v[0] && !cs_v[0]) lat <= bus0;

  rtc_bus_master u_dut0 (
    .clk(clk), .reset(reset), .req(req_v[0]), .rw(rw), .addr(addr), .burst_len(burst_len),
    .wdata(wdata), .wdata_take(take_v[0]), .rdata(rdata_v[0]), .rdata_valid(rv_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .add_data_rtc(bus0),
    .a_d_s(ad_v[0]), .cs_s(cs_v[0]), .rd_s(rd_v[0]), .wr_s(wr_v[0]));

  rtc_bus_master #(.ADDR_INC(0)) u_dut1 (
    .clk(clk), .reset(reset), .req(req_v[1]), .rw(rw), .addr(addr), .burst_len(burst_len),
    .wdata(wdata), .wdata_take(take_v[1]), .rdata(rdata_v[1]), .rdata_valid(rv_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .add_data_rtc(bus1),
    .a_d_s(ad_v[1]), .cs_s(cs_v[1]), .rd_s(rd_v[1]), .wr_s(wr_v[1]));

  rtc_bus_master #(.T_STB(0)) u_dut2 (
    .clk(clk), .reset(reset), .req(req_v[2]), .rw(rw), .addr(addr), .burst_len(burst_len),
    .wdata(wdata), .wdata_take(take_v[2]), .rdata(rdata_v[2]), .rdata_valid(rv_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .add_data_rtc(bus2),
    .a_d_s(ad_v[2]), .cs_s(cs_v[2]), .rd_s(rd_v[2]), .wr_s(wr_v[2]));

  int total = 0;
  int bad   = 0;

  int         cursel, rel, n_ad, n_cs, n_busy, both_low, bad_drive, busy_low_rel, widx;
  logic       cs_prev;
  bit         adv_pending;
  logic [7:0] wl[$];
  logic [7:0] addrs[$], wdq[$], rdq[$];
  int         takes[$], dones[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int qfirst(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  // Keeps the last four bytes of a log, oldest in the upper byte.
  function automatic logic [31:0] pack(input logic [7:0] q[$]);
    logic [31:0] r;
    r = '0;
    foreach (q[i]) r = {r[23:0], q[i]};
    return r;
  endfunction

  task automatic clear_stats();
    rel = 0; n_ad = 0; n_cs = 0; n_busy = 0; both_low = 0; bad_drive = 0;
    busy_low_rel = 0; cs_prev = 1'b1; adv_pending = 1'b0;
    addrs.delete(); wdq.delete(); rdq.delete(); takes.delete(); dones.delete();
  endtask

  task automatic step();
    logic s_ad, s_cs, s_rd, s_wr, s_take, s_rv, s_busy, s_done;
    logic [7:0] b;
    @(negedge clk);
    rel++;
    if (adv_pending) begin
      adv_pending = 1'b0;
      widx++;
      if (widx < wl.size()) wdata = wl[widx];
    end
    s_ad = ad_v[cursel]; s_cs = cs_v[cursel]; s_rd = rd_v[cursel]; s_wr = wr_v[cursel];
    s_take = take_v[cursel]; s_rv = rv_v[cursel]; s_busy = busy_v[cursel]; s_done = done_v[cursel];
    case (cursel)
      0:       b = bus0;
      1:       b = bus1;
      default: b = bus2;
    endcase
    if (!s_ad) n_ad++;
    if (!s_cs) n_cs++;
    if (!s_cs && !s_ad && cs_prev) addrs.push_back(b);
    cs_prev = s_cs;
    if (!s_wr && s_ad) wdq.push_back(b);
    if (s_take) begin
      takes.push_back(rel);
      adv_pending = 1'b1;
    end
    if (s_rv) rdq.push_back(rdata_v[cursel]);
    if (s_done) dones.push_back(rel);
    if (s_busy) n_busy++;
    if (!s_busy && busy_low_rel == 0) busy_low_rel = rel;
    if (!s_rd && !s_wr) both_low++;
    if (cursel == 0 && model_en && s_ad && s_busy && b !== model_val) bad_drive++;
  endtask

  task automatic start_tx(input int sel, input logic r, input logic [7:0] a, input logic [3:0] l);
    @(negedge clk);
    cursel = sel; rw = r; addr = a; burst_len = l;
    widx = 0;
    wdata = (wl.size() > 0) ? wl[0] : 8'h00;
    clear_stats();
    req_v[sel] = 1'b1;
  endtask

  task automatic run_tx(input int sel, input logic r, input logic [7:0] a, input logic [3:0] l,
                        input int window, input int extra_req);
    start_tx(sel, r, a, l);
    for (int i = 0; i < window; i++) begin
      step();
      req_v[sel] = (rel == extra_req);
    end
    req_v[sel] = 1'b0;
  endtask

  initial begin
    int found;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) req_v[i] = 1'b0;
    rw = 1'b0; addr = '0; burst_len = '0; wdata = '0;
    model_en = 1'b0; model_inc = 1'b0; cursel = 0; widx = 0;
    clear_stats();
    repeat (3) step();
    check("rst_a_d_s", {ad_v[0], ad_v[1], ad_v[2]}, 3'b111);
    check("rst_cs_s",  {cs_v[0], cs_v[1], cs_v[2]}, 3'b111);
    check("rst_rd_s",  {rd_v[0], rd_v[1], rd_v[2]}, 3'b111);
    check("rst_wr_s",  {wr_v[0], wr_v[1], wr_v[2]}, 3'b111);
    check("rst_busy_done", {busy_v[0], busy_v[1], busy_v[2], done_v[0], done_v[1], done_v[2]}, 6'b0);
    check("rst_take_rv", {take_v[0], take_v[1], take_v[2], rv_v[0], rv_v[1], rv_v[2]}, 6'b0);
    check("rst_rdata", rdata_v[0], 8'h00);
    reset = 1'b0;

    // single write at default timing
    wl = '{8'h5C};
    run_tx(0, 1'b1, 8'h0A, 4'd1, 16, -1);
    check("wr_ad_low_cycles", n_ad, 5);
    check("wr_addr_count", addrs.size(), 1);
    check("wr_addr", pack(addrs), 32'h0A);
    check("wr_data_cycles", wdq.size(), 3);
    check("wr_data", pack(wdq), 32'h005C5C5C);
    check("wr_take_count", takes.size(), 1);
    check("wr_done_cycle", qfirst(dones), 13);
    check("wr_busy_low_cycle", busy_low_rel, 14);
    check("wr_done_count", dones.size(), 1);

    // single read, model answers 0x37
    model_en = 1'b1; model_inc = 1'b0;
    run_tx(0, 1'b0, 8'h0A, 4'd1, 16, -1);
    check("rd_valid_count", rdq.size(), 1);
    check("rd_data", pack(rdq), 32'h37);
    check("rd_no_master_drive", bad_drive, 0);
    check("rd_done_cycle", qfirst(dones), 13);
    check("rd_strobe_overlap", both_low, 0);

    // burst read across the address wrap, model answers reg+1
    model_inc = 1'b1;
    run_tx(0, 1'b0, 8'hFE, 4'd3, 40, -1);
    check("brd_addr_count", addrs.size(), 3);
    check("brd_addrs", pack(addrs), 32'h00FEFF00);
    check("brd_valid_count", rdq.size(), 3);
    check("brd_rdata", pack(rdq), 32'h00FF0001);
    check("brd_done_cycle", qfirst(dones), 37);
    check("brd_no_master_drive", bad_drive, 0);
    model_en = 1'b0;

    // fixed-address burst write
    wl = '{8'h11, 8'h22};
    run_tx(1, 1'b1, 8'h40, 4'd2, 28, -1);
    check("fix_addr_count", addrs.size(), 2);
    check("fix_addrs", pack(addrs), 32'h4040);
    check("fix_data_cycles", wdq.size(), 6);
    check("fix_data", pack(wdq), 32'h11222222);
    check("fix_take_count", takes.size(), 2);
    check("fix_take_spacing", (takes.size() == 2) ? takes[1] - takes[0] : -1, 12);
    check("fix_done_cycle", qfirst(dones), 25);

    // zero strobe parameter behaves as one cycle
    wl = '{8'h99};
    run_tx(2, 1'b1, 8'h33, 4'd1, 12, -1);
    check("tstb0_data_cycles", wdq.size(), 1);
    check("tstb0_data", pack(wdq), 32'h99);
    check("tstb0_cs_cycles", n_cs, 2);
    check("tstb0_addr", pack(addrs), 32'h33);
    check("tstb0_done_cycle", qfirst(dones), 9);

    // burst_len of zero runs one word
    wl = '{8'hA1};
    run_tx(0, 1'b1, 8'h10, 4'd0, 16, -1);
    check("len0_done_cycle", qfirst(dones), 13);
    check("len0_take_count", takes.size(), 1);
    check("len0_data", pack(wdq), 32'h00A1A1A1);

    // request while busy is dropped
    wl = '{8'hB2};
    run_tx(0, 1'b1, 8'h11, 4'd1, 30, 5);
    check("busyreq_done_count", dones.size(), 1);
    check("busyreq_busy_cycles", n_busy, 13);

    // reset during a write data strobe
    wl = '{8'hA7};
    start_tx(0, 1'b1, 8'h21, 4'd1);
    found = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      req_v[0] = 1'b0;
      if (!wr_v[0] && ad_v[0]) begin
        found = 1;
        break;
      end
    end
    check("rstmid_reached_dstb", found, 1);
    reset = 1'b1; model_en = 1'b1; model_inc = 1'b0;
    step();
    check("rstmid_strobes", {ad_v[0], cs_v[0], rd_v[0], wr_v[0]}, 4'b1111);
    check("rstmid_busy_done", {busy_v[0], done_v[0]}, 2'b00);
    check("rstmid_bus_released", bus0, 8'h37);
    reset = 1'b0;
    clear_stats();
    repeat (6) step();
    check("rstmid_no_done", dones.size(), 0);
    check("rstmid_idle", n_busy, 0);
    run_tx(0, 1'b0, 8'h21, 4'd1, 16, -1);
    check("rstmid_after_rdata", pack(rdq), 32'h37);
    check("rstmid_after_done", qfirst(dones), 13);
    model_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
